// File: rtl/detector_top.sv
// detector_top: grey -> Sobel -> threshold -> raster component labels.
// Three enabled-cycle register stages; line buffers are never cleared.
module detector_top #(
  parameter int MAX_WIDTH  = 1024,
  parameter int PIXEL_SIZE = 24,
  parameter int THRESHOLD  = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic [PIXEL_SIZE-1:0] data,
  output logic [PIXEL_SIZE-1:0] out
);
  localparam int AW = (MAX_WIDTH > 2) ? $clog2(MAX_WIDTH) : 2;
  localparam int RW = 12;

  typedef logic [AW-1:0] col_t;
  typedef logic [RW-1:0] row_t;

  typedef struct packed {
    logic       v;
    logic       sof;
    logic [7:0] g;
    col_t       col;
    col_t       last;
    row_t       row;
  } s1_t;

  typedef struct packed {
    logic       v;
    logic       sof;
    logic [7:0] mag;
    col_t       col;
    col_t       last;
    row_t       row;
  } s2_t;

  // reset_n is asserted high despite its name
  logic rst;
  assign rst = reset_n;

  col_t col_q, last_q;
  row_t row_q;
  logic seen_q;
  s1_t  s1;
  s2_t  s2;

  logic       hs;
  logic [9:0] gsum;
  logic [7:0] g8;
  col_t       col_d, last_d;
  row_t       row_d;

  always_comb begin
    hs     = hsync | vsync;
    gsum   = {2'b00, data[23:16]}
           + {1'b0, data[15:8], 1'b0}
           + {2'b00, data[7:0]};
    g8     = 8'(gsum >> 2);
    col_d  = (col_q == col_t'(MAX_WIDTH-1))
           ? '0 : col_q + col_t'(1);
    last_d = last_q;
    row_d  = row_q;
    if (hs) begin
      col_d  = '0;
      last_d = col_q;
      if (vsync || !seen_q) row_d = '0;
      else if (row_q != '1) row_d = row_q + row_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      last_q <= '0;
      row_q  <= '0;
      seen_q <= 1'b0;
      s1     <= '0;
    end else if (en) begin
      col_q   <= col_d;
      last_q  <= last_d;
      row_q   <= row_d;
      seen_q  <= seen_q | hs;
      s1.v    <= 1'b1;
      s1.sof  <= vsync;
      s1.g    <= g8;
      s1.col  <= col_d;
      s1.last <= last_d;
      s1.row  <= row_d;
    end
  end

  logic [7:0] lb1 [MAX_WIDTH];
  logic [7:0] lb2 [MAX_WIDTH];
  logic [7:0] t1_q, t2_q, m1_q, m2_q, b1_q, b2_q;
  logic [7:0] top, mid;

  function automatic logic signed [10:0] ext(
    input logic [7:0] p
  );
    return $signed({3'b000, p});
  endfunction

  logic signed [10:0] gx, gy;
  logic [10:0] ax, ay;
  logic [11:0] sum;
  logic [7:0]  mag;

  // window: *2 = col-2, *1 = col-1, top/mid/g = current column
  always_comb begin
    top = lb2[s1.col];
    mid = lb1[s1.col];
    gx  = (ext(top) + (ext(mid) <<< 1) + ext(s1.g))
        - (ext(t2_q) + (ext(m2_q) <<< 1) + ext(b2_q));
    gy  = (ext(b2_q) + (ext(b1_q) <<< 1) + ext(s1.g))
        - (ext(t2_q) + (ext(t1_q) <<< 1) + ext(top));
    ax  = gx[10] ? 11'(-gx) : 11'(gx);
    ay  = gy[10] ? 11'(-gy) : 11'(gy);
    sum = {1'b0, ax} + {1'b0, ay};
    mag = (|sum[11:8]) ? 8'hFF : sum[7:0];
    if (s1.row < row_t'(2) || s1.col < col_t'(2))
      mag = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2   <= '0;
      t1_q <= '0;
      t2_q <= '0;
      m1_q <= '0;
      m2_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
    end else if (en) begin
      s2.v    <= s1.v;
      s2.sof  <= s1.sof;
      s2.mag  <= mag;
      s2.col  <= s1.col;
      s2.last <= s1.last;
      s2.row  <= s1.row;
      if (s1.v) begin
        t2_q <= t1_q;
        t1_q <= top;
        m2_q <= m1_q;
        m1_q <= mid;
        b2_q <= b1_q;
        b1_q <= s1.g;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && en && s1.v) begin
      lb1[s1.col] <= s1.g;
      lb2[s1.col] <= mid;
    end
  end

  logic [7:0] lbl_buf [MAX_WIDTH];
  logic [7:0] left_q, up_q, ur_q, cnt_q;
  col_t       nxt_col;
  logic [7:0] rd_ur, up_raw;
  logic [7:0] left, ul, up, ur;
  logic [7:0] t, lbl, base, cnt_d;

  // up-left/up come from earlier up-right reads of this same buffer
  always_comb begin
    nxt_col = (s2.col == col_t'(MAX_WIDTH-1))
            ? '0 : s2.col + col_t'(1);
    rd_ur   = lbl_buf[nxt_col];
    up_raw  = (s2.col == '0) ? lbl_buf[s2.col] : ur_q;
    left    = left_q;
    ul      = up_q;
    up      = up_raw;
    ur      = rd_ur;
    if (s2.row == '0) begin
      ul = '0;
      up = '0;
      ur = '0;
    end
    if (s2.col == '0) begin
      left = '0;
      ul   = '0;
    end
    if (s2.col == s2.last) ur = '0;
    t     = (s2.mag >= 8'(THRESHOLD)) ? 8'hFF : 8'h00;
    base  = s2.sof ? 8'h00 : cnt_q;
    cnt_d = base;
    lbl   = '0;
    if (t[0]) begin
      if (left != '0)    lbl = left;
      else if (ul != '0) lbl = ul;
      else if (up != '0) lbl = up;
      else if (ur != '0) lbl = ur;
      else begin
        cnt_d = (base == 8'hFF) ? 8'hFF : base + 8'd1;
        lbl   = cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '0;
      cnt_q  <= '0;
      left_q <= '0;
      up_q   <= '0;
      ur_q   <= '0;
    end else if (en && s2.v) begin
      out    <= {s2.mag, t, lbl};
      cnt_q  <= cnt_d;
      left_q <= lbl;
      up_q   <= up_raw;
      ur_q   <= rd_ur;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && en && s2.v)
      lbl_buf[s2.col] <= lbl;
  end

endmodule

// File: tb/tb_detector_top.sv
// tb_detector_top: directed frames against hand-derived expected outputs.
// Output after driving pixel k belongs to pixel k-2 (sampled #1 after edge).
module tb_detector_top;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        hsync;
  logic        vsync;
  logic [23:0] data;
  logic [23:0] out;

  int errs   = 0;
  int checks = 0;

  detector_top dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .hsync  (hsync),
    .vsync  (vsync),
    .data   (data),
    .out    (out)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [23:0] got,
    input logic [23:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(
    input int t, input int r, input int c
  );
    case (t)
      1: return 24'h808080;
      2: return (c >= 4) ? 24'hFFFFFF : 24'h000000;
      3: return (c >= 3 && c <= 7) ? 24'hFFFFFF : 24'h000000;
      default:
        return (r >= 2 && r <= 34 && (r-2) % 4 == 0 &&
                c >= 2 && c <= 122 && (c-2) % 4 == 0)
               ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] expv(
    input int t, input int r, input int c
  );
    logic [23:0] e;
    int j, a, k, b, n;
    e = '0;
    case (t)
      2: if (r >= 2 && (c == 4 || c == 5)) e = 24'hFFFF01;
      3: begin
        if (r >= 2 && (c == 3 || c == 4)) e = 24'hFFFF01;
        if (r >= 2 && (c == 8 || c == 9)) e = 24'hFFFF02;
      end
      4: if (r >= 2 && c >= 2) begin
        j = (r-2) / 4;
        a = (r-2) % 4;
        k = (c-2) / 4;
        b = (c-2) % 4;
        if (j <= 8 && k <= 30 && a < 3 && b < 3 &&
            !(a == 1 && b == 1)) begin
          n = j*31 + k + 1;
          e = {16'hFFFF, (n > 255) ? 8'hFF : 8'(n)};
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic drive(
    input logic [23:0] d, input logic hs, input logic vs
  );
    en    = 1'b1;
    data  = d;
    hsync = hs;
    vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(
    input int t, input int w, input int rows, input int stall_at
  );
    int n;
    int p;
    logic [23:0] held;
    n = w * rows;
    for (int k = 0; k < n + 2; k++) begin
      if (k == stall_at) begin
        p    = k - 3;
        held = expv(t, p / w, p % w);
        en    = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        data  = 24'h5A5A5A;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk);
          #1;
          chk($sformatf("stall%0d", s), out, held);
        end
      end
      if (k < n)
        drive(pix(t, k / w, k % w), (k % w) == 0, k == 0);
      else
        drive(24'h0, 1'b0, 1'b0);
      if (k >= 2) begin
        p = k - 2;
        chk($sformatf("t%0d r%0d c%0d", t, p / w, p % w),
            out, expv(t, p / w, p % w));
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    en      = 1'b1;
    hsync   = 1'b1;
    vsync   = 1'b1;
    data    = 24'hFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset%0d", i), out, 24'h0);
    end
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(24'h0, 1'b0, 1'b0);
      chk($sformatf("idle%0d", i), out, 24'h0);
    end

    run_frame(1, 8, 6, -1);
    run_frame(2, 8, 6, -1);
    run_frame(2, 8, 6, 31);
    run_frame(3, 12, 5, -1);
    run_frame(3, 12, 5, -1);

    for (int k = 0; k < 36; k++)
      drive(pix(3, k / 12, k % 12), (k % 12) == 0, k == 0);
    chk("pre_reset", out, 24'hFFFF02);
    reset_n = 1'b1;
    drive(24'hFFFFFF, 1'b1, 1'b1);
    chk("mid_reset", out, 24'h0);
    reset_n = 1'b0;

    run_frame(4, 128, 37, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/detector_top.md
# detector_top

Streaming image-analysis pipeline for the detection datapath: accepts one 24-bit RGB pixel per enabled clock in raster order and returns one 24-bit result per pixel. The result carries a Sobel edge magnitude, a binary threshold of that magnitude, and a single-pass connected-component label. It sits between the frame source (rows framed by `hsync`/`vsync`) and the colour-mapping/output stage.

## Interface
- `MAX_WIDTH`, 1024: maximum row length in pixels; sets line-buffer depth.
- `PIXEL_SIZE`, 24: pixel width in bits.
- `THRESHOLD`, 128: edge threshold applied to the 8-bit Sobel magnitude.
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: reset, synchronous and active-high (asserted when 1).
- `en` in 1: pixel enable. When 0, all state and `out` hold.
- `hsync` in 1: high in the same cycle as the first pixel of each row.
- `vsync` in 1: high in the same cycle as the first pixel of a frame. It also implies `hsync`.
- `data` in 24: pixel, with `[23:16]`=R, `[15:8]`=G, `[7:0]`=B.
- `out` out 24: `[23:16]` Sobel magnitude, `[15:8]` threshold (0x00/0xFF), `[7:0]` component label.

## Operation
- Grey conversion: `g = (R + 2*G + B) >> 2`. Compute in a 10-bit sum, giving an 8-bit result.
- Position counters:
  - `col` resets to 0 on `hsync` and otherwise increments per enabled pixel.
  - `row` increments on `hsync`, except on the first `hsync` after reset or on `vsync`, where it is set to 0.
- Sobel:
  - Two grey line buffers of `MAX_WIDTH` are indexed by `col`. Together with the current pixel they form a 3x3 window whose bottom-right is the current input.
  - `Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)` and `Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)`, in 11-bit signed.
  - `mag = |Gx| + |Gy|`, saturated to 255.
  - When `row < 2` or `col < 2`, `mag` is forced to 0.
- Threshold: `t = (mag >= THRESHOLD) ? 0xFF : 0x00`.
- Connected components (raster, 8-connectivity, no equivalence merging):
  - A label line buffer holds the previous row's labels. Up neighbours are treated as 0 when `row == 0`.
  - Left neighbours are treated as 0 when `col == 0`.
  - Background (`t == 0`) gets label 0.
  - Foreground takes the first non-zero label in priority order: left, up-left, up, up-right.
  - If all four are 0, the label counter increments and its new value is assigned. The counter saturates at 255, and further new components get 255.
- The label counter resets to 0 on reset and on `vsync`.
- Line-buffer contents are not cleared by reset. Border masking guarantees deterministic output.

## Timing
- Three register stages:
  - S1: grey plus counters.
  - S2: Sobel magnitude.
  - S3: threshold, label and output register.
- `out` reflects the pixel sampled 3 enabled cycles earlier. All three fields are aligned to the same pixel.
- Latency is counted in enabled cycles. With `en` low the pipeline freezes with no bubble insertion.
- Reset: `out`=0, counters=0, label counter=0, pipeline valid flags cleared. Reset dominates `en`, `hsync` and `vsync` in the same cycle.
- Reset asserted mid-frame: the next frame restarts cleanly from the next `hsync`.
- `hsync` and `vsync` are sampled only when `en`=1.
- A row longer than `MAX_WIDTH` wraps the buffer index modulo `MAX_WIDTH`. Output for that row is undefined but must not hang.
- The up-right neighbour at `col == width-1` reads the stale buffer entry and must be masked to 0. The row width is latched from `col` at each `hsync`.

## Test plan
- Reset held 2 cycles, then released with `en`=1 and `data`=0 → `out`=0x000000 every cycle.
- Uniform frame `data`=0x808080, width 8 → every `out`=0x000000 and no label allocated.
- Width 8, columns 0-3 grey 0 and columns 4-7 R=G=B=0xFF:
  - At `row >= 2`, the pixels whose window spans the edge give `out[23:16]`=0xFF, `[15:8]`=0xFF, label 1.
  - All other pixels give 0.
- Two separate vertical edges in the same frame → first edge labelled 1, second labelled 2. A new frame with `vsync` restarts labelling at 1.
- `en` dropped for 5 cycles mid-row → `out` holds its value, and the output sequence after resuming equals the un-stalled sequence.
- More than 255 isolated single-pixel edges in one frame → labels saturate at 0xFF with no wrap to 0.
